// File: rtl/hazard_pkg.sv
// Shared pipeline definitions for the ID-stage hazard controller.
package hazard_pkg;

  // Controller state encodings
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STALL  = 2'd1;
  localparam logic [1:0] ST_MCBUSY = 2'd2;

  // $zero is hardwired, so it never creates a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    StRun    = ST_RUN,
    StStall  = ST_STALL,
    StMcBusy = ST_MCBUSY
  } hazardState_e;

  // Stall-cycle demand from a single hazard evaluation (0, 1 or 2 cycles)
  typedef logic [1:0] stallNeed_t;

endpackage

// File: rtl/hazard_match.sv
// Register-dependency compare with the zero-register guard.
module hazard_match
  import hazard_pkg::*;
(
  input  logic       compareEn,
  input  logic [4:0] srcReg,
  input  logic [4:0] dstReg,
  output logic       match
);

  // A write to $zero is architecturally invisible, so it never matches
  always_comb begin
    match = compareEn && (dstReg != REG_ZERO) && (dstReg == srcReg);
  end

endmodule

// File: rtl/hazard_stall_control.sv
// ID-stage hazard controller: stalls or flushes wherever EX forwarding cannot cover a hazard
// (load-use, branch operands compared in ID, multi-cycle ops).
// Optional build macro: HAZARD_PERF_EN adds saturating StallCycles / FlushCount counters.
module hazard_stall_control
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_MultiCycle,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_WriteReg,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_WriteReg,
  input  logic             EX_BranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXBubble,
  output logic             IFIDFlush,
  output logic             Busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
`endif
);

  // The 4-bit counter and MCBUSY reload both rely on this range
  if (MC_LAT < 2 || MC_LAT > 15 || CNT_W == 0) begin : gen_param_check
    $error("hazard_stall_control: MC_LAT must be 2..15 and CNT_W nonzero");
  end

  localparam logic [3:0] McReload = 4'(MC_LAT - 2);

  hazardState_e stateQ, stateD;
  logic [3:0]   cntQ, cntD;

  logic       exRsMatch, exRtMatch, memRsMatch, memRtMatch;
  logic       exMatch, memMatch;
  stallNeed_t stallNeed;

  logic         evalStall;
  hazardState_e evalState;
  logic [3:0]   evalCnt;

  hazard_match uExRs (
    .compareEn (1'b1),
    .srcReg    (ID_rs),
    .dstReg    (EX_WriteReg),
    .match     (exRsMatch)
  );

  hazard_match uExRt (
    .compareEn (ID_UsesRt),
    .srcReg    (ID_rt),
    .dstReg    (EX_WriteReg),
    .match     (exRtMatch)
  );

  hazard_match uMemRs (
    .compareEn (1'b1),
    .srcReg    (ID_rs),
    .dstReg    (MEM_WriteReg),
    .match     (memRsMatch)
  );

  hazard_match uMemRt (
    .compareEn (ID_UsesRt),
    .srcReg    (ID_rt),
    .dstReg    (MEM_WriteReg),
    .match     (memRtMatch)
  );

  // Stall demand of the instr in ID; branch-on-load from EX is the worst case
  always_comb begin
    exMatch  = exRsMatch || exRtMatch;
    memMatch = memRsMatch || memRtMatch;
    if (ID_Branch && EX_MemRead && exMatch) begin
      stallNeed = 2'd2;
    end else if (exMatch && (EX_MemRead || (ID_Branch && EX_RegWrite))) begin
      stallNeed = 2'd1;
    end else if (ID_Branch && MEM_MemRead && memMatch) begin
      stallNeed = 2'd1;
    end else begin
      stallNeed = 2'd0;
    end
  end

  // Outcome of a fresh evaluation; a data hazard outranks starting a multi-cycle op
  always_comb begin
    evalStall = (stallNeed != 2'd0);
    evalState = StRun;
    evalCnt   = 4'd0;
    if (evalStall) begin
      evalState = StStall;
      evalCnt   = {2'b00, stallNeed} - 4'd1;
    end else if (ID_MultiCycle) begin
      evalState = StMcBusy;
      evalCnt   = McReload;
    end
  end

  // State and counter register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateQ <= StRun;
      cntQ   <= 4'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Next state and pipeline-control outputs; the detecting cycle already stalls
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    stateD     = stateQ;
    cntD       = cntQ;

    if (EX_BranchTaken) begin
      // Redirect wins everywhere; an in-flight multi-cycle op simply completes in EX
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      stateD     = StRun;
      cntD       = 4'd0;
    end else begin
      unique case (stateQ)
        StRun: begin
          if (evalStall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
          end
          stateD = evalState;
          cntD   = evalCnt;
        end
        StStall: begin
          if (cntQ != 4'd0) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            cntD       = cntQ - 4'd1;
          end else begin
            // Exit cycle: the ID instr is re-evaluated against the advanced pipeline
            if (evalStall) begin
              PCWrite    = 1'b0;
              IFIDWrite  = 1'b0;
              IDEXBubble = 1'b1;
            end
            stateD = evalState;
            cntD   = evalCnt;
          end
        end
        StMcBusy: begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
          if (cntQ == 4'd0) begin
            stateD = StRun;
          end else begin
            cntD = cntQ - 4'd1;
          end
        end
        default: begin
          stateD = StRun;
          cntD   = 4'd0;
        end
      endcase
    end
  end

  // Busy flags any non-RUN state
  always_comb begin
    Busy = (stateQ != StRun);
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stallCntQ, flushCntQ;

  // Saturating performance counters
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (!PCWrite && (stallCntQ != {CNT_W{1'b1}})) begin
        stallCntQ <= stallCntQ + CNT_W'(1);
      end
      if (IFIDFlush && (flushCntQ != {CNT_W{1'b1}})) begin
        flushCntQ <= flushCntQ + CNT_W'(1);
      end
    end
  end

  assign StallCycles = stallCntQ;
  assign FlushCount  = flushCntQ;
`endif

endmodule

// File: tb/tb_hazard_stall_control.sv
// Directed, table-driven bench for hazard_stall_control (MC_LAT=4).
module tb_hazard_stall_control;

  logic       Clk, Reset;
  logic [4:0] ID_rs, ID_rt, EX_WriteReg, MEM_WriteReg;
  logic       ID_UsesRt, ID_Branch, ID_MultiCycle, EX_MemRead, EX_RegWrite, MEM_MemRead;
  logic       EX_BranchTaken;
  logic       PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  int checks   = 0;
  int failures = 0;

  hazard_stall_control #(
    .MC_LAT (4),
    .CNT_W  (32)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .ID_UsesRt      (ID_UsesRt),
    .ID_Branch      (ID_Branch),
    .ID_MultiCycle  (ID_MultiCycle),
    .EX_MemRead     (EX_MemRead),
    .EX_RegWrite    (EX_RegWrite),
    .EX_WriteReg    (EX_WriteReg),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_WriteReg   (MEM_WriteReg),
    .EX_BranchTaken (EX_BranchTaken),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IDEXBubble     (IDEXBubble),
    .IFIDFlush      (IFIDFlush),
    .Busy           (Busy)
`ifdef HAZARD_PERF_EN
    ,
    .StallCycles    (StallCycles),
    .FlushCount     (FlushCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // exp = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Busy}
  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       br;
    logic       mc;
    logic       exMr;
    logic       exRw;
    logic [4:0] exWr;
    logic       memMr;
    logic [4:0] memWr;
    logic       brTaken;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [4:0] rs, logic [4:0] rt, logic usesRt,
                              logic br, logic mc, logic exMr, logic exRw, logic [4:0] exWr,
                              logic memMr, logic [4:0] memWr, logic brTaken, logic [4:0] exp);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.usesRt = usesRt; v.br = br; v.mc = mc;
    v.exMr = exMr; v.exRw = exRw; v.exWr = exWr; v.memMr = memMr; v.memWr = memWr;
    v.brTaken = brTaken; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ID_rs = v.rs; ID_rt = v.rt; ID_UsesRt = v.usesRt; ID_Branch = v.br;
    ID_MultiCycle = v.mc; EX_MemRead = v.exMr; EX_RegWrite = v.exRw; EX_WriteReg = v.exWr;
    MEM_MemRead = v.memMr; MEM_WriteReg = v.memWr; EX_BranchTaken = v.brTaken;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [4:0] outs();
    return {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Busy};
  endfunction

  int expStalls = 0;
  int expFlushes = 0;

  initial begin
    // name rs rt usesRt br mc exMr exRw exWr memMr memWr brTaken exp
    vecs.push_back(mk("idle",        0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b11000));
    vecs.push_back(mk("loadUse",     8,  0, 0, 0, 0, 1, 1,  8, 0,  0, 0, 5'b00100));
    vecs.push_back(mk("loadUseExit", 8,  0, 0, 0, 0, 0, 0,  0, 1,  8, 0, 5'b11001));
    vecs.push_back(mk("idle2",       0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b11000));
    vecs.push_back(mk("lwBeq",       9,  8, 1, 1, 0, 1, 1,  8, 0,  0, 0, 5'b00100));
    vecs.push_back(mk("lwBeqHold",   9,  8, 1, 1, 0, 0, 0,  0, 1,  8, 0, 5'b00101));
    vecs.push_back(mk("lwBeqExit",   9,  8, 1, 1, 0, 0, 0,  0, 0,  0, 0, 5'b11001));
    vecs.push_back(mk("lwBeqNoRt",   9,  8, 0, 1, 0, 1, 1,  8, 0,  0, 0, 5'b11000));
    vecs.push_back(mk("zeroReg",     0,  0, 0, 1, 0, 0, 1,  0, 0,  0, 0, 5'b11000));
    vecs.push_back(mk("brAlu",      10,  0, 0, 1, 0, 0, 1, 10, 0,  0, 0, 5'b00100));
    vecs.push_back(mk("brAluExit",  10,  0, 0, 1, 0, 0, 0,  0, 0, 10, 0, 5'b11001));
    vecs.push_back(mk("brMemLoad",  11,  0, 0, 1, 0, 0, 0,  0, 1, 11, 0, 5'b00100));
    vecs.push_back(mk("brMemExit",  11,  0, 0, 1, 0, 0, 0,  0, 0,  0, 0, 5'b11001));
    vecs.push_back(mk("mcIssue",     1,  2, 1, 0, 1, 0, 0,  0, 0,  0, 0, 5'b11000));
    vecs.push_back(mk("mcHold1",     3,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b00101));
    vecs.push_back(mk("mcHold2",     3,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b00101));
    vecs.push_back(mk("mcHold3",     3,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b00101));
    vecs.push_back(mk("mcDone",      3,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b11000));
    vecs.push_back(mk("mcIssue2",    1,  2, 1, 0, 1, 0, 0,  0, 0,  0, 0, 5'b11000));
    vecs.push_back(mk("mcBr1",       3,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b00101));
    vecs.push_back(mk("mcBrFlush",   3,  0, 0, 0, 0, 0, 0,  0, 0,  0, 1, 5'b11111));
    vecs.push_back(mk("afterFlush",  0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b11000));
    vecs.push_back(mk("brRun",       8,  0, 0, 0, 0, 1, 1,  8, 0,  0, 1, 5'b11110));
    vecs.push_back(mk("mcLoadUse",   5,  0, 0, 0, 1, 1, 1,  5, 0,  0, 0, 5'b00100));
    vecs.push_back(mk("mcAftStall",  5,  0, 0, 0, 1, 0, 0,  0, 1,  5, 0, 5'b11001));
    vecs.push_back(mk("mcHoldB1",    6,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b00101));
    vecs.push_back(mk("mcHoldB2",    6,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b00101));
    vecs.push_back(mk("mcHoldB3",    6,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b00101));
    vecs.push_back(mk("idle3",       0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b11000));
    vecs.push_back(mk("reLoad1",     8,  0, 0, 0, 0, 1, 1,  8, 0,  0, 0, 5'b00100));
    vecs.push_back(mk("reLoad2",     9,  0, 0, 0, 0, 1, 1,  9, 0,  0, 0, 5'b00101));
    vecs.push_back(mk("reExit",      0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b11001));
    vecs.push_back(mk("loadUseRt",   1,  8, 1, 0, 0, 1, 1,  8, 0,  0, 0, 5'b00100));
    vecs.push_back(mk("loadRtExit",  1,  8, 1, 0, 0, 0, 0,  0, 1,  8, 0, 5'b11001));
    vecs.push_back(mk("idle4",       0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 5'b11000));

    // Reset state
    Reset = 1'b0;
    drive(vecs[0]);
    #3;
    check("resetOutputs", 32'(outs()), 32'(5'b11000));
    @(posedge Clk);
    #1 Reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #2;
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      if (!vecs[i].exp[4]) expStalls++;
      if (vecs[i].exp[1]) expFlushes++;
      @(posedge Clk);
      #1;
    end

`ifdef HAZARD_PERF_EN
    check("perfStallCycles", StallCycles, 32'(expStalls));
    check("perfFlushCount", FlushCount, 32'(expFlushes));
`endif

    // Reset asserted mid-STALL (branch on load from EX leaves one more stall cycle)
    drive(mk("rstLwBeq", 9, 8, 1, 1, 0, 1, 1, 8, 0, 0, 0, 5'b00100));
    #2;
    check("rstLwBeq", 32'(outs()), 32'(5'b00100));
    @(posedge Clk);
    #1;
    drive(mk("rstHold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00101));
    #2;
    check("rstMidStallBefore", 32'(outs()), 32'(5'b00101));
    Reset = 1'b0;
    #1;
    check("rstMidStallAfter", 32'(outs()), 32'(5'b11000));
`ifdef HAZARD_PERF_EN
    check("perfStallAfterReset", StallCycles, 32'd0);
    check("perfFlushAfterReset", FlushCount, 32'd0);
`endif
    @(posedge Clk);
    #1 Reset = 1'b1;
    drive(mk("postRstLoadUse", 4, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 5'b00100));
    #2;
    check("postRstLoadUse", 32'(outs()), 32'(5'b00100));
    @(posedge Clk);
    #1;
    drive(mk("postRstExit", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001));
    #2;
    check("postRstExit", 32'(outs()), 32'(5'b11001));
`ifdef HAZARD_PERF_EN
    check("perfStallIncrement", StallCycles, 32'd1);
`endif
    @(posedge Clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
